chain_score_sched: RTL and testbench
====================================

// Module: chain_score_sched
// PURPOSE
//  Sequences the pairwise chaining-score datapath (computeScorepp) for one anchor stream.
//  For each new anchor i, issues (i,j) pairs for up to MAX_PRED preceding anchors, nearest first.
//  Collects each pair score, forms f(i) = max(w_i, f(j)+score_ij) over eligible j, and emits f(i)
//  plus the best predecessor offset. Sits between the anchor loader and the backtrack/output stage.
// PARAMETERS
//  MAX_PRED   16    max predecessors examined per anchor (>=1)
//  DEPTH      32    anchor/score ring entries; power of 2, DEPTH > MAX_PRED
//  SCORE_LAT  8     fixed cycles from sc_issue to valid sc_result (>=1)
//  MAX_DIST   5000  max x-distance (x_i - x_j) for an eligible predecessor
// PORTS
//  clk          in   1   clock, rising edge
//  reset_n      in   1   asynchronous, active-low reset
//  in_valid     in   1   anchor valid
//  in_ready     out  1   anchor accept; handshake = in_valid & in_ready
//  in_x/in_y    in   32  reference / query position, unsigned
//  in_w         in   32  anchor span (seed score), signed
//  in_last      in   1   last anchor of current read; window clears after it
//  sc_issue     out  1   pair valid to score unit
//  sc_riX/sc_riY out 32  x_i / x_j
//  sc_qiX/sc_qiY out 32  y_i / y_j
//  sc_W         out  32  w_i
//  sc_result    in   32  signed pair score, valid SCORE_LAT cycles after its sc_issue
//  out_valid    out  1   result valid
//  out_ready    in   1   result accept
//  out_score    out  32  f(i), signed
//  out_pred     out  $clog2(MAX_PRED+1)  best predecessor offset (1 = previous anchor), 0 = none
// BEHAVIOUR
//  Reset (reset_n=0, any state): FSM->IDLE; in_ready, sc_issue, out_valid = 0; all sc_*, out_score,
//   out_pred = 0; wr_ptr = 0, count = 0; SCORE_LAT tag pipe cleared. Ring contents don't care.
//  FSM: IDLE -> ISSUE -> DRAIN -> OUT -> IDLE.
//  - IDLE: in_ready=1 (only state where it is 1).
//    On accept: write x,y,w to ring[wr_ptr]; latch last flag; n = min(count, MAX_PRED); best = in_w; bpred = 0.
//    n==0 -> OUT next cycle. Else -> ISSUE.
//  - ISSUE: one pair per cycle for k=1..n, j = (wr_ptr-k) mod DEPTH; sc_issue=1, outputs registered.
//    elig_k = (x_i > x_j) & (y_i > y_j) & (x_i - x_j <= MAX_DIST), computed at issue.
//    {elig_k, k} enter a SCORE_LAT-deep tag pipe. After k=n -> DRAIN.
//  - DRAIN (also active during ISSUE): on each returning tag, cand = f[j] + sc_result (32-bit signed, wraps).
//    If elig & cand > best, then best = cand and bpred = k. Strict >, so ties keep the smaller k.
//    When last tag returns -> OUT.
//  - OUT: out_valid=1; out_score=best, out_pred=bpred, held stable until out_ready.
//    On handshake: f[wr_ptr] = best; wr_ptr++ (mod DEPTH); count = last ? 0 : min(count+1, MAX_PRED); -> IDLE.
//  Latency: accept at T -> out_valid at T+1 (n=0) or T+n+SCORE_LAT+1 (n>0). Throughput 1 anchor per n+SCORE_LAT+2 cycles, minimum.
//  sc_result ignored in cycles with no returning tag. out_ready ignored unless out_valid.
//  Wrap: ring indices mod DEPTH; DEPTH > MAX_PRED guarantees no overwrite of live predecessors.
// TESTING
//  1. Reset, anchor (100,200,w=15): no sc_issue, out_valid at accept+1, score=15, pred=0.
//  2. Anchors (100,200,15), (150,260,15), stub sc_result=10: one issue riX=150 riY=100 qiX=260 qiY=200;
//     second out at accept+SCORE_LAT+2, score=25, pred=1.
//  3. Second anchor y=150 (ineligible) or x=5200 (dist 5100 > MAX_DIST): score=w, pred=0; issue still occurs.
//  4. 20 increasing anchors, constant sc_result=5: anchor 17+ gets exactly 16 issues (k=1..16).
//     Equal candidates resolve to pred=1.
//  5. in_last on anchor 3: anchor 4 gets 0 issues, score=w; out_ready low 5 cycles holds outputs, in_ready=0.
//  6. reset_n low mid-ISSUE: outputs 0 immediately; next anchor treated as first (no issues).

Source files
------------

// File: rtl/chain_score_sched.sv
// Chaining-score scheduler: for each anchor, issues (i,j) pairs to the pair-score unit for up to
// MaxPred preceding anchors and reduces the returned scores into f(i) and the best predecessor.
module chain_score_sched #(
  parameter int unsigned MaxPred  = 16,
  parameter int unsigned Depth    = 32,
  parameter int unsigned ScoreLat = 8,
  parameter int unsigned MaxDist  = 5000,
  localparam int unsigned PredW   = $clog2(MaxPred + 1),
  localparam int unsigned PtrW    = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      in_x_i,
  input  logic [31:0]      in_y_i,
  input  logic [31:0]      in_w_i,
  input  logic             in_last_i,
  output logic             sc_issue_o,
  output logic [31:0]      sc_rix_o,
  output logic [31:0]      sc_riy_o,
  output logic [31:0]      sc_qix_o,
  output logic [31:0]      sc_qiy_o,
  output logic [31:0]      sc_w_o,
  input  logic [31:0]      sc_result_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_score_o,
  output logic [PredW-1:0] out_pred_o
);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StOut} state_e;

  typedef struct packed {
    logic             vld;
    logic             elig;
    logic             last;
    logic [PredW-1:0] k;
  } tag_t;

  state_e state_q, state_d;

  logic [31:0]        x_ring [Depth];
  logic [31:0]        y_ring [Depth];
  logic signed [31:0] f_ring [Depth];

  logic [31:0]        cur_x_q, cur_x_d, cur_y_q, cur_y_d, cur_w_q, cur_w_d;
  logic               last_q, last_d;
  logic [PredW-1:0]   n_q, n_d, k_q, k_d, count_q, count_d, bpred_q, bpred_d;
  logic signed [31:0] best_q, best_d;
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic               in_ready_q, in_ready_d, sc_issue_q, sc_issue_d;
  logic [31:0]        sc_rix_q, sc_rix_d, sc_riy_q, sc_riy_d, sc_qix_q, sc_qix_d;
  logic [31:0]        sc_qiy_q, sc_qiy_d, sc_w_q, sc_w_d;
  logic               out_valid_q, out_valid_d;
  logic [31:0]        out_score_q, out_score_d;
  logic [PredW-1:0]   out_pred_q, out_pred_d;
  tag_t               iss_tag_q, iss_tag_d;
  tag_t               tag_q [ScoreLat];

  logic               accept, iss_go, elig;
  logic [PredW-1:0]   iss_k, iss_n, bpred_upd;
  logic [31:0]        xi, yi, wi, xj, yj;
  logic [PtrW-1:0]    j_idx;
  tag_t               ret;
  logic signed [31:0] f_ret, cand, best_upd;

  always_comb begin
    accept    = in_valid_i & in_ready_q;
    ret       = tag_q[ScoreLat-1];
    f_ret     = f_ring[wr_ptr_q - PtrW'(ret.k)];
    cand      = f_ret + $signed(sc_result_i);
    best_upd  = best_q;
    bpred_upd = bpred_q;
    // Strict compare: on ties the earlier-returning (nearer) predecessor wins.
    if (ret.vld && ret.elig && (cand > best_q)) begin
      best_upd  = cand;
      bpred_upd = ret.k;
    end

    state_d     = state_q;
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    cur_w_d     = cur_w_q;
    last_d      = last_q;
    n_d         = n_q;
    k_d         = k_q;
    count_d     = count_q;
    best_d      = best_upd;
    bpred_d     = bpred_upd;
    wr_ptr_d    = wr_ptr_q;
    out_valid_d = out_valid_q;
    out_score_d = out_score_q;
    out_pred_d  = out_pred_q;
    sc_issue_d  = 1'b0;
    sc_rix_d    = sc_rix_q;
    sc_riy_d    = sc_riy_q;
    sc_qix_d    = sc_qix_q;
    sc_qiy_d    = sc_qiy_q;
    sc_w_d      = sc_w_q;
    iss_tag_d   = '0;
    iss_go      = 1'b0;
    iss_k       = k_q;
    iss_n       = n_q;
    xi          = cur_x_q;
    yi          = cur_y_q;
    wi          = cur_w_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          cur_x_d = in_x_i;
          cur_y_d = in_y_i;
          cur_w_d = in_w_i;
          last_d  = in_last_i;
          n_d     = count_q;
          best_d  = $signed(in_w_i);
          bpred_d = '0;
          k_d     = PredW'(2);
          if (count_q == '0) begin
            state_d     = StOut;
            out_valid_d = 1'b1;
            out_score_d = in_w_i;
            out_pred_d  = '0;
          end else begin
            // First pair goes out on the accept edge to save a cycle of latency.
            iss_go  = 1'b1;
            iss_k   = PredW'(1);
            iss_n   = count_q;
            xi      = in_x_i;
            yi      = in_y_i;
            wi      = in_w_i;
            state_d = (count_q == PredW'(1)) ? StDrain : StIssue;
          end
        end
      end
      StIssue: begin
        iss_go = 1'b1;
        k_d    = k_q + PredW'(1);
        if (k_q == n_q) state_d = StDrain;
      end
      StDrain: begin
        if (ret.vld && ret.last) begin
          state_d     = StOut;
          out_valid_d = 1'b1;
          out_score_d = best_upd;
          out_pred_d  = bpred_upd;
        end
      end
      StOut: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          wr_ptr_d    = wr_ptr_q + PtrW'(1);
          if (last_q)                         count_d = '0;
          else if (count_q != PredW'(MaxPred)) count_d = count_q + PredW'(1);
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    j_idx = wr_ptr_q - PtrW'(iss_k);
    xj    = x_ring[j_idx];
    yj    = y_ring[j_idx];
    elig  = (xi > xj) && (yi > yj) && ((xi - xj) <= MaxDist);
    if (iss_go) begin
      sc_issue_d     = 1'b1;
      sc_rix_d       = xi;
      sc_riy_d       = xj;
      sc_qix_d       = yi;
      sc_qiy_d       = yj;
      sc_w_d         = wi;
      iss_tag_d.vld  = 1'b1;
      iss_tag_d.elig = elig;
      iss_tag_d.last = (iss_k == iss_n);
      iss_tag_d.k    = iss_k;
    end
    in_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cur_x_q     <= '0;
      cur_y_q     <= '0;
      cur_w_q     <= '0;
      last_q      <= 1'b0;
      n_q         <= '0;
      k_q         <= '0;
      count_q     <= '0;
      best_q      <= '0;
      bpred_q     <= '0;
      wr_ptr_q    <= '0;
      in_ready_q  <= 1'b0;
      sc_issue_q  <= 1'b0;
      sc_rix_q    <= '0;
      sc_riy_q    <= '0;
      sc_qix_q    <= '0;
      sc_qiy_q    <= '0;
      sc_w_q      <= '0;
      out_valid_q <= 1'b0;
      out_score_q <= '0;
      out_pred_q  <= '0;
      iss_tag_q   <= '0;
      for (int i = 0; i < ScoreLat; i++) tag_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      cur_w_q     <= cur_w_d;
      last_q      <= last_d;
      n_q         <= n_d;
      k_q         <= k_d;
      count_q     <= count_d;
      best_q      <= best_d;
      bpred_q     <= bpred_d;
      wr_ptr_q    <= wr_ptr_d;
      in_ready_q  <= in_ready_d;
      sc_issue_q  <= sc_issue_d;
      sc_rix_q    <= sc_rix_d;
      sc_riy_q    <= sc_riy_d;
      sc_qix_q    <= sc_qix_d;
      sc_qiy_q    <= sc_qiy_d;
      sc_w_q      <= sc_w_d;
      out_valid_q <= out_valid_d;
      out_score_q <= out_score_d;
      out_pred_q  <= out_pred_d;
      iss_tag_q   <= iss_tag_d;
      tag_q[0]    <= iss_tag_q;
      for (int i = 1; i < ScoreLat; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // Ring storage needs no reset; count_q gates which entries are ever read.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      x_ring[wr_ptr_q] <= in_x_i;
      y_ring[wr_ptr_q] <= in_y_i;
    end
    if ((state_q == StOut) && out_ready_i) f_ring[wr_ptr_q] <= out_score_q;
  end

  assign in_ready_o  = in_ready_q;
  assign sc_issue_o  = sc_issue_q;
  assign sc_rix_o    = sc_rix_q;
  assign sc_riy_o    = sc_riy_q;
  assign sc_qix_o    = sc_qix_q;
  assign sc_qiy_o    = sc_qiy_q;
  assign sc_w_o      = sc_w_q;
  assign out_valid_o = out_valid_q;
  assign out_score_o = out_score_q;
  assign out_pred_o  = out_pred_q;

endmodule

// File: tb/tb_chain_score_sched.sv
// Bench for chain_score_sched: directed scenarios plus random anchor streams, checked against a
// queue-based model of the chaining recurrence and a stub pair-score unit.
module tb_chain_score_sched;

  localparam int L  = 8;
  localparam int MP = 16;
  localparam int MD = 5000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, in_last = 1'b0;
  logic [31:0] in_x = '0, in_y = '0, in_w = '0;
  logic        sc_issue;
  logic [31:0] sc_rix, sc_riy, sc_qix, sc_qiy, sc_w, sc_result = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_score;
  logic [4:0]  out_pred;

  chain_score_sched #(.MaxPred(MP), .Depth(32), .ScoreLat(L), .MaxDist(MD)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_x_i(in_x), .in_y_i(in_y), .in_w_i(in_w), .in_last_i(in_last),
    .sc_issue_o(sc_issue), .sc_rix_o(sc_rix), .sc_riy_o(sc_riy),
    .sc_qix_o(sc_qix), .sc_qiy_o(sc_qiy), .sc_w_o(sc_w), .sc_result_i(sc_result),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_score_o(out_score), .out_pred_o(out_pred)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  bit          const_mode = 1'b1;
  logic [31:0] const_val  = 32'd10;

  typedef struct packed {
    logic [31:0] rix, riy, qix, qiy, w;
  } pair_t;

  typedef struct {
    logic [31:0]        x, y;
    logic signed [31:0] f;
  } anc_t;

  pair_t iss_log[$];
  anc_t  hist[$];
  logic [31:0] dl [L];

  function automatic logic [31:0] stub(logic [31:0] rix, logic [31:0] riy,
                                       logic [31:0] qix, logic [31:0] qiy);
    if (const_mode) return const_val;
    return ((rix ^ riy) + qix * 3 + qiy) % 61 - 30;
  endfunction

  // Pair-score stub: answer every issued pair exactly L cycles later, junk otherwise.
  always @(posedge clk) begin
    #1;
    sc_result = dl[L-1];
    for (int i = L - 1; i > 0; i--) dl[i] = dl[i-1];
    dl[0] = sc_issue ? stub(sc_rix, sc_riy, sc_qix, sc_qiy) : $urandom;
  end

  always @(negedge clk) begin
    if (sc_issue) iss_log.push_back('{sc_rix, sc_riy, sc_qix, sc_qiy, sc_w});
  end

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [31:0] w,
                      input bit last, input int hold);
    int                 n, bp, lat, t, exp_lat;
    pair_t              exp_p[$];
    anc_t               p, a;
    logic signed [31:0] best, cand;
    bit                 el;
    n    = hist.size();
    best = $signed(w);
    bp   = 0;
    for (int k = 1; k <= n; k++) begin
      p  = hist[n-k];
      el = (x > p.x) && (y > p.y) && ((x - p.x) <= MD);
      exp_p.push_back('{x, p.x, y, p.y, w});
      cand = p.f + $signed(stub(x, p.x, y, p.y));
      if (el && cand > best) begin
        best = cand;
        bp   = k;
      end
    end
    exp_lat = (n == 0) ? 1 : n + L + 1;

    @(negedge clk);
    in_valid = 1'b1; in_x = x; in_y = y; in_w = w; in_last = last;
    t = 0;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    iss_log.delete();
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    check("latency", lat, exp_lat);
    if (!out_valid) return;
    check("issue_count", iss_log.size(), n);
    for (int k = 0; k < n && k < iss_log.size(); k++) check("issue_pair", iss_log[k], exp_p[k]);
    check("score", {128'b0, out_score}, {128'b0, best});
    check("pred", out_pred, bp);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_score", {128'b0, out_score}, {128'b0, best});
      check("hold_pred", out_pred, bp);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;

    if (last) hist.delete();
    else begin
      a.x = x; a.y = y; a.f = best;
      hist.push_back(a);
      if (hist.size() > MP) void'(hist.pop_front());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rx, ry, rw;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_sc_issue", sc_issue, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_score", out_score, 0);
    check("rst_out_pred", out_pred, 0);
    check("rst_sc_rix", sc_rix, 0);
    rst_n = 1'b1;

    // Single anchor, then one eligible predecessor
    const_mode = 1'b1; const_val = 32'd10;
    send(100, 200, 15, 0, 0);
    send(150, 260, 15, 1, 0);

    // Ineligible by y order and by distance
    send(100, 200, 15, 0, 0);
    send(150, 150, 15, 1, 0);
    send(100, 200, 15, 0, 0);
    send(5200, 260, 15, 1, 0);

    // Window cap at MP predecessors with equal candidates
    const_val = 32'd5;
    for (int i = 0; i < 20; i++) send(1000 + 100 * i, 1000 + 100 * i, 1, i == 19, 0);

    // in_last clears the window; output backpressure
    send(10, 10, 3, 0, 0);
    send(20, 20, 3, 0, 0);
    send(30, 30, 3, 1, 0);
    send(40, 40, 7, 0, 5);
    send(50, 50, 2, 1, 0);

    // Reset while issuing
    send(10, 10, 3, 0, 0);
    send(20, 20, 3, 0, 0);
    send(30, 30, 3, 0, 0);
    @(negedge clk);
    in_valid = 1'b1; in_x = 40; in_y = 40; in_w = 3; in_last = 1'b0;
    while (!in_ready) @(negedge clk);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_issue", sc_issue, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_sc_issue", sc_issue, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_sc_rix", sc_rix, 0);
    check("mid_rst_out_score", out_score, 0);
    @(negedge clk);
    rst_n = 1'b1;
    hist.delete();
    send(500, 500, 9, 0, 0);

    // Random streams with hashed pair scores
    const_mode = 1'b0;
    rx = 32'd1000; ry = 32'd1000;
    for (int i = 0; i < 70; i++) begin
      if ($urandom_range(0, 9) == 0) rx = rx - 50; else rx = rx + $urandom_range(0, 3000);
      if ($urandom_range(0, 9) == 0) ry = ry - 50; else ry = ry + $urandom_range(0, 1500);
      rw = $urandom_range(0, 200) - 50;
      send(rx, ry, rw, $urandom_range(0, 24) == 0,
           ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
